// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared state encoding, fault codes and default PWM width for the LED string dimmer
package led_ctrl_pkg;
  localparam int PWM_BITS_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'b00, SOFT = 2'b01, RUN = 2'b10, FAULT = 2'b11} state_t;
  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_OPEN = 2'b01;
  localparam logic [1:0] FC_SHORT = 2'b10;
  localparam logic [1:0] FC_BOTH = 2'b11;
endpackage

// File: rtl/led_fault_filter.sv
// led_fault_filter: saturating consecutive-cycle counter; hit when a qualified comparator stays high FAULT_FILT cycles
// Ports: clk, rst_n (async low), qual (comparator may be trusted), cmp (comparator), hit (limit reached this cycle)
module led_fault_filter #(
  parameter int FAULT_FILT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic qual,
  input  logic cmp,
  output logic hit
);
  logic [3:0] count, count_nxt;
  always_comb begin
    count_nxt = (qual && cmp) ? ((count == 4'(FAULT_FILT)) ? count : count + 4'd1) : 4'd0;
    hit = count_nxt == 4'(FAULT_FILT);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= 4'd0;
    else count <= count_nxt;
endmodule

// File: rtl/led_string_dimmer.sv
// led_string_dimmer: PWM drive, soft-start and open/short fault latch for a constant-current LED string
// Ports: clk, rst_n (async low), en, duty_wr/duty_in (shadow duty load), vf_open/vf_short (comparators),
//        drive (source enable), period_start (cnt==0 pulse), fault, fault_code, state
module led_string_dimmer import led_ctrl_pkg::*; #(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int SS_STEP = 1,
  parameter int FAULT_FILT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                duty_wr,
  input  logic [PWM_BITS-1:0] duty_in,
  input  logic                vf_open,
  input  logic                vf_short,
  output logic                drive,
  output logic                period_start,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic [1:0]          state
);
  state_t st, st_nxt;
  logic [PWM_BITS-1:0] cnt, duty_cur, duty_cur_nxt, duty_shadow, shadow_nxt, duty_act, act_nxt, ramp;
  logic [PWM_BITS:0] sum;
  logic [1:0] code_nxt;
  logic wrap, run, drive_d, qual, drive_nxt, hit_open, hit_short;
  led_fault_filter #(.FAULT_FILT(FAULT_FILT)) u_open (
    .clk(clk), .rst_n(rst_n), .qual(qual), .cmp(vf_open), .hit(hit_open)
  );
  led_fault_filter #(.FAULT_FILT(FAULT_FILT)) u_short (
    .clk(clk), .rst_n(rst_n), .qual(qual), .cmp(vf_short), .hit(hit_short)
  );
  assign state = st;
  assign fault = st == FAULT;
  // second cycle of a drive-high run onward: switching transients are blanked
  assign qual = drive && drive_d;
  always_comb begin
    wrap = cnt == {PWM_BITS{1'b1}};
    run = st == SOFT || st == RUN;
    shadow_nxt = duty_wr ? duty_in : duty_shadow;
    act_nxt = wrap ? shadow_nxt : duty_act;
    sum = {1'b0, duty_cur} + (PWM_BITS+1)'(SS_STEP);
    // one step toward the target, never past it; also snaps straight down on a decrease
    ramp = (sum > {1'b0, act_nxt}) ? act_nxt : sum[PWM_BITS-1:0];
    st_nxt = st;
    duty_cur_nxt = duty_cur;
    code_nxt = fault_code;
    if (!en && st != IDLE) begin
      st_nxt = IDLE;
      duty_cur_nxt = '0;
      code_nxt = FC_NONE;
    end else if (run && (hit_open || hit_short)) begin
      st_nxt = FAULT;
      duty_cur_nxt = '0;
      code_nxt = {hit_short, hit_open};
    end else if (st == IDLE) begin
      duty_cur_nxt = '0;
      st_nxt = (en && wrap) ? SOFT : IDLE;
    end else if (run && wrap) begin
      duty_cur_nxt = ramp;
      st_nxt = (ramp == act_nxt) ? RUN : SOFT;
    end
    drive_nxt = (st_nxt == SOFT || st_nxt == RUN) && cnt < duty_cur;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      duty_cur <= '0;
      duty_shadow <= '0;
      duty_act <= '0;
      fault_code <= FC_NONE;
      drive <= 1'b0;
      drive_d <= 1'b0;
      period_start <= 1'b0;
    end else begin
      st <= st_nxt;
      cnt <= cnt + PWM_BITS'(1);
      duty_cur <= duty_cur_nxt;
      duty_shadow <= shadow_nxt;
      duty_act <= act_nxt;
      fault_code <= code_nxt;
      drive <= drive_nxt;
      drive_d <= drive;
      period_start <= wrap;
    end
endmodule

// File: tb/tb_led_string_dimmer.sv
// tb_led_string_dimmer: directed scoreboard bench for led_string_dimmer (SS_STEP=1 main unit, SS_STEP=255 side unit)
module tb_led_string_dimmer;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, duty_wr = 1'b0, vf_open = 1'b0, vf_short = 1'b0;
  logic [7:0] duty_in = 8'd0;
  logic drive_a, ps_a, fault_a, drive_b, ps_b, fault_b;
  logic [1:0] code_a, state_a, code_b, state_b;
  int cyc, checks, passes, hi;
  typedef struct {string tag; int exp;} item_t;
  item_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  led_string_dimmer #(.PWM_BITS(8), .SS_STEP(1), .FAULT_FILT(4)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .duty_wr(duty_wr), .duty_in(duty_in),
    .vf_open(vf_open), .vf_short(vf_short), .drive(drive_a), .period_start(ps_a),
    .fault(fault_a), .fault_code(code_a), .state(state_a)
  );
  led_string_dimmer #(.PWM_BITS(8), .SS_STEP(255), .FAULT_FILT(4)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .duty_wr(duty_wr), .duty_in(duty_in),
    .vf_open(vf_open), .vf_short(vf_short), .drive(drive_b), .period_start(ps_b),
    .fault(fault_b), .fault_code(code_b), .state(state_b)
  );
  task automatic push(string tag, int exp);
    sb.push_back('{tag, exp});
  endtask
  task automatic pop_check(logic [31:0] obs);
    item_t it;
    checks++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %0d with nothing expected", obs);
      return;
    end
    it = sb.pop_front();
    assert (obs === it.exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", it.tag, obs, it.exp);
  endtask
  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic count_until(bit b, int n, output int h);
    h = 0;
    while (cyc < n) begin
      @(negedge clk);
      h += b ? int'(drive_b) : int'(drive_a);
    end
  endtask
  task automatic write_duty(logic [7:0] d);
    duty_wr = 1'b1;
    duty_in = d;
    @(negedge clk);
    duty_wr = 1'b0;
  endtask
  initial begin
    push("rst_drive", 0); push("rst_fault", 0); push("rst_code", 0); push("rst_state", 0); push("rst_ps", 0);
    repeat (3) @(negedge clk);
    pop_check(drive_a); pop_check(fault_a); pop_check(code_a); pop_check(state_a); pop_check(ps_a);
    rst_n = 1'b1;
    wait_cyc(9);
    en = 1'b1;
    write_duty(8'd64);
    push("idle_before_wrap", 0); wait_cyc(255); pop_check(state_a);
    push("soft_first_wrap", 1); push("period_start_hi", 1);
    wait_cyc(256); pop_check(state_a); pop_check(ps_a);
    push("period_start_lo", 0); @(negedge clk); pop_check(ps_a);
    push("ramp_hi3", 3); wait_cyc(1024); count_until(0, 1280, hi); pop_check(hi);
    push("soft_at_63", 1); wait_cyc(256*64); pop_check(state_a);
    push("run_at_64", 2); wait_cyc(256*65); pop_check(state_a);
    push("run_hi64", 64); count_until(0, 256*66, hi); pop_check(hi);
    push("drive_edge_hi", 1); wait_cyc(256*66+64); pop_check(drive_a);
    push("drive_edge_lo", 0); @(negedge clk); pop_check(drive_a);
    write_duty(8'd200);
    push("no_midperiod_change", 0); count_until(0, 256*67, hi); pop_check(hi);
    push("soft_on_increase", 1); pop_check(state_a);
    push("ramp_65", 65); count_until(0, 256*68, hi); pop_check(hi);
    push("ramp_66", 66); count_until(0, 256*69, hi); pop_check(hi);
    wait_cyc(256*69+100);
    write_duty(8'd0);
    push("run_after_drop", 2); wait_cyc(256*70); pop_check(state_a);
    push("duty0_hi", 0); count_until(0, 256*71, hi); pop_check(hi);
    push("still_run_duty0", 2); pop_check(state_a);
    wait_cyc(256*71+50);
    write_duty(8'd255);
    push("b_run_255", 2); push("a_soft_255", 1);
    wait_cyc(256*72); pop_check(state_b); pop_check(state_a);
    push("b_hi255", 255); count_until(1, 256*73, hi); pop_check(hi);
    push("b_lo_cnt255", 0); pop_check(drive_b);
    push("b_hi_cnt0", 1); @(negedge clk); pop_check(drive_b);
    wait_cyc(256*91+100);
    vf_open = 1'b1;
    wait_cyc(256*91+120);
    vf_open = 1'b0;
    push("no_fault_drive_low", 0); @(negedge clk); pop_check(fault_a);
    wait_cyc(256*92+1);
    vf_open = 1'b1;
    wait_cyc(256*92+5);
    vf_open = 1'b0;
    push("blanked_no_fault", 0); push("blanked_state", 1);
    @(negedge clk); pop_check(fault_a); pop_check(state_a);
    wait_cyc(256*92+10);
    vf_open = 1'b1;
    wait_cyc(256*92+14);
    vf_open = 1'b0;
    push("open_fault", 1); push("open_code", 1); push("open_state", 3); push("open_drive", 0);
    pop_check(fault_a); pop_check(code_a); pop_check(state_a); pop_check(drive_a);
    push("fault_code_held", 1); push("fault_ps", 1);
    wait_cyc(256*93); pop_check(code_a); pop_check(ps_a);
    push("fault_drive_hi", 0); count_until(0, 256*94, hi); pop_check(hi);
    en = 1'b0;
    push("exit_state", 0); push("exit_fault", 0); push("exit_code", 0);
    @(negedge clk); pop_check(state_a); pop_check(fault_a); pop_check(code_a);
    en = 1'b1;
    wait_cyc(256*105+3);
    vf_open = 1'b1;
    vf_short = 1'b1;
    wait_cyc(256*105+7);
    vf_open = 1'b0;
    vf_short = 1'b0;
    push("both_code", 3); push("both_state", 3);
    pop_check(code_a); pop_check(state_a);
    en = 1'b0;
    push("both_exit_state", 0); push("both_exit_fault", 0); push("both_exit_code", 0);
    @(negedge clk); pop_check(state_a); pop_check(fault_a); pop_check(code_a);
    en = 1'b1;
    push("resoft_state", 1); wait_cyc(256*106); pop_check(state_a);
    push("resoft_hi0", 0); count_until(0, 256*107, hi); pop_check(hi);
    push("pre_reset_drive", 1); @(negedge clk); pop_check(drive_a);
    #1 rst_n = 1'b0;
    push("async_drive", 0); push("async_state", 0);
    #1 pop_check(drive_a); pop_check(state_a);
    @(negedge clk);
    rst_n = 1'b1;
    push("post_rst_soft", 1); wait_cyc(256); pop_check(state_a);
    push("post_rst_run", 2); wait_cyc(512); pop_check(state_a);
    push("post_rst_hi0", 0); count_until(0, 768, hi); pop_check(hi);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
